// File: rtl/seg7_result_display.sv
// Four-digit multiplexed seven-segment driver showing the adder result byte,
// carry-out and byte-select, refreshed one digit per REFRESH_DIV clocks.
module seg7_result_display #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] out,
    input  logic       cout,
    input  logic [1:0] select,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic [15:0] cnt;
    logic        tick;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic [7:0]  shadow_out;
    logic        shadow_cout;
    logic [1:0]  shadow_select;
    logic [3:0]  digit_val;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        tick     = (cnt == REFRESH_DIV - 16'd1);
        idx_next = idx + 2'd1;
        digit_val = '0;
        case (idx_next)
            // Digit 0 takes the live inputs, which are being captured on this same tick.
            2'd0:    digit_val = out[3:0];
            2'd1:    digit_val = shadow_out[7:4];
            2'd2:    digit_val = {3'b000, shadow_cout};
            default: digit_val = {2'b00, shadow_select};
        endcase
        seg_next = hex7(digit_val);
        an_next  = ~(4'b0001 << idx_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= 2'd3;
            shadow_out    <= '0;
            shadow_cout   <= 1'b0;
            shadow_select <= '0;
            an            <= '1;
            seg           <= '1;
            dp            <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 16'd1;
            if (tick) begin
                idx <= idx_next;
                seg <= seg_next;
                if (idx == 2'd3) begin
                    shadow_out    <= out;
                    shadow_cout   <= cout;
                    shadow_select <= select;
                end
            end
            // Blank overrides anodes immediately; they only come back on a tick.
            if (blank) begin
                an <= '1;
                dp <= 1'b1;
            end else if (tick) begin
                an <= an_next;
                dp <= (idx_next != 2'd2);
            end
        end
    end

endmodule

// File: doc/seg7_result_display.md
SEG7_RESULT_DISPLAY -- requirements
Module: seg7_result_display

Interface
REQ-001 Parameter: REFRESH_DIV, 16'd50000, number of clk cycles per digit slot; legal range 2..65535.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 out  input  8  result byte from the adder controller.
REQ-006 cout  input  1  carry-out from the adder controller.
REQ-007 select  input  2  byte-select currently applied to the adder controller.
REQ-008 blank  input  1  synchronous display blank; 1 = all digits off.
REQ-009 an  output  4  digit anodes, active-low; an[k] enables digit k.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Prescaler: 16-bit counter, counts 0..REFRESH_DIV-1 and wraps to 0; "tick" is asserted in the cycle where the count equals REFRESH_DIV-1.
REQ-013 Digit index: 2-bit register, advances 0->1->2->3->0 on each tick and holds otherwise.
REQ-014 Frame snapshot: on a tick where the index is 3 (the move to 0), out, cout and select are captured into shadow registers; the shadow registers hold at all other times.
REQ-015 Digit 0 of each frame is driven from the values captured on that same tick; no input change takes effect mid-frame.
REQ-016 Digit content:
- digit 0 = hex of shadow out[3:0]
- digit 1 = hex of shadow out[7:4]
- digit 2 = '0' or '1' from shadow cout
- digit 3 = shadow select shown as 0..3
REQ-017 dp is 0 only while digit 2 is lit; otherwise dp = 1.
REQ-018 Hex codes (gfedcba, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-019 an, seg and dp are registered and load on tick with the values for the new index; a digit is lit from the cycle after its tick through the cycle of the next tick inclusive.
REQ-020 Exactly one an bit is 0 whenever the display is enabled and past its first tick.
REQ-021 blank = 1 drives an = 4'b1111 and dp = 1 at the next clock edge, independent of tick; the prescaler, index and snapshot keep running.
REQ-022 On blank falling to 0, an resumes at the next tick; blanking never corrupts the shadow registers.
REQ-023 rst has priority over blank and tick when asserted in the same cycle.

Reset
REQ-024 While rst = 1, at each clock edge:
- prescaler = 0
- digit index = 3
- shadow out = 8'h00, shadow cout = 0, shadow select = 2'b00
- an = 4'b1111, seg = 7'b1111111, dp = 1
REQ-025 Reset asserted mid-frame applies REQ-024 at the next edge; the first tick after release (REFRESH_DIV cycles later) lights digit 0 and performs a snapshot.

Verification (REFRESH_DIV = 4)
REQ-026 Reset, then out = 8'h3C, cout = 1, select = 2'b10:
- cycle 4 after release: an = 1110, seg = 1000110 (C)
- cycle 8: an = 1101, seg = 0110000 (3)
- cycle 12: an = 1011, seg = 1111001, dp = 0
- cycle 16: an = 0111, seg = 0100100 (2)
- cycle 20: an = 1110 again
REQ-027 Tearing: change out to 8'hA5 while digit 1 is lit -> digits 1-3 keep frame values (3, cout, select); the next digit 0 shows 0010010 (5), then digit 1 shows 0001000 (A).
REQ-028 Sweep out over 8'h00..8'hFF, one value per frame -> digits 0 and 1 match the REQ-018 table for all 16 nibble values.
REQ-029 Blank: blank = 1 for 10 cycles mid-frame -> an = 1111 one cycle later; after release, an is valid at the next tick with the digit sequence unbroken.
REQ-030 Reset: rst pulsed for 1 cycle while digit 2 is lit -> an = 1111, seg = 1111111, dp = 1 next cycle; digit 0 is lit 4 cycles after release.
